// File: rtl/ats_timer_array.sv
// Alarm/timer engine: N_CLK prescaled base counters feeding N_AT alarm/timer channels,
// configured by two 16-bit ports that each deliver a 32-bit command over two beats.

module ats_channel #(
   parameter int N_CLK   = 16,
   parameter int CW      = 16,
   parameter int PULSE_W = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       i_cmd_vld,
   input  logic [1:0]                 i_cmd_op,
   input  logic                       i_flag,
   input  logic                       i_mode,
   input  logic [3:0]                 i_src,
   input  logic [CW-1:0]              i_val,
   input  logic [N_CLK-1:0]           i_ev,
   input  logic [N_CLK-1:0][CW-1:0]   i_cnt,
   output logic                       o_data
);
   logic          r_en, r_mode, r_tmr, r_arm, r_rpt, r_lat;
   logic [3:0]    r_src, r_pcnt;
   logic [CW-1:0] r_val, r_rem;
   logic          w_ev, w_hit, w_fire;
   logic [CW-1:0] w_cnt;

   assign w_ev   = i_ev[r_src];
   assign w_cnt  = i_cnt[r_src];
   // Timer expires when remaining is 1 (normal) or 0 (loaded as zero).
   assign w_hit  = r_arm && w_ev && (r_tmr ? (r_rem <= CW'(1)) : (w_cnt == r_val));
   assign w_fire = w_hit && r_en;
   assign o_data = r_lat || (r_pcnt != 4'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_en <= 1'b0; r_mode <= 1'b0; r_tmr <= 1'b0; r_arm <= 1'b0;
         r_rpt <= 1'b0; r_lat <= 1'b0; r_src <= '0; r_pcnt <= '0;
         r_val <= '0; r_rem <= '0;
      end else begin
         if (r_pcnt != 4'd0) r_pcnt <= r_pcnt - 4'd1;
         if (i_cmd_vld) begin
            case (i_cmd_op)
               2'b00: r_lat <= 1'b0;
               2'b01: begin
                  r_val <= i_val; r_src <= i_src; r_rpt <= i_flag;
                  r_arm <= 1'b1;  r_tmr <= 1'b0;
               end
               2'b10: begin
                  r_val <= i_val; r_rem <= i_val; r_src <= i_src;
                  r_rpt <= i_flag; r_arm <= 1'b1; r_tmr <= 1'b1;
               end
               default: begin
                  r_en <= i_flag; r_mode <= i_mode;
                  if (!i_flag) r_lat <= 1'b0;
               end
            endcase
         end else if (w_hit) begin
            if (w_fire) begin
               if (r_mode) r_lat  <= 1'b1;
               else        r_pcnt <= 4'(PULSE_W);
            end
            if (r_tmr) begin
               if (r_rpt) r_rem <= r_val;
               else       r_arm <= 1'b0;
            end else if (w_fire && !r_rpt) r_arm <= 1'b0;
         end else if (r_arm && w_ev && r_tmr) begin
            r_rem <= r_rem - CW'(1);
         end
      end
   end
endmodule

module ats_timer_array #(
   parameter int N_CLK   = 16,
   parameter int N_AT    = 24,
   parameter int CW      = 16,
   parameter int PULSE_W = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            req,
   input  logic [15:0]     ctrlA,
   input  logic [15:0]     ctrlB,
   output logic            ready,
   output logic [1:0]      stat,
   output logic [N_AT-1:0] data
);
   localparam logic [5:0] LP_NCLK = 6'(N_CLK);
   localparam logic [5:0] LP_NAT  = 6'(N_AT);

   typedef enum logic [1:0] {S_HI = 2'd0, S_LO = 2'd1, S_EXEC = 2'd2} state_t;
   state_t r_state, w_nxt;

   logic                     r_live;
   logic [1:0][31:0]         r_cmd;
   logic [1:0]               r_stat;
   logic [2:0]               r_presc;
   logic [N_CLK-1:0][CW-1:0] r_cnt;
   logic [N_CLK-1:0][1:0]    r_rate;
   logic [N_CLK-1:0]         r_cen, r_ev;
   logic                     w_exec, w_acc, w_conf, w_unused;
   logic [1:0][2:0]          w_op;
   logic [1:0][4:0]          w_idx;
   logic [1:0]               w_isclk, w_isch, w_ok, w_vld, w_rej;
   logic [N_CLK-1:0]         w_ck_hit, w_ck_sel, w_tick;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_HI;
         r_live  <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_live  <= 1'b1;
      end
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_HI:    if (w_acc) w_nxt = S_LO;
         S_LO:    if (w_acc) w_nxt = S_EXEC;
         S_EXEC:  w_nxt = S_HI;
         default: w_nxt = S_HI;
      endcase
   end

   always_comb begin
      ready  = r_live && (r_state != S_EXEC);
      w_exec = (r_state == S_EXEC);
   end

   assign w_acc    = req && ready;
   assign stat     = r_stat;
   assign w_unused = ^{r_cmd[0][20], r_cmd[1][20]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_cmd <= '0;
      else if (w_acc) begin
         if (r_state == S_HI) begin
            r_cmd[0][31:16] <= ctrlA; r_cmd[1][31:16] <= ctrlB;
         end else begin
            r_cmd[0][15:0]  <= ctrlA; r_cmd[1][15:0]  <= ctrlB;
         end
      end
   end

   // Decode both ports; B loses to a valid A targeting the same counter or channel.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_op[p]    = r_cmd[p][31:29];
         w_idx[p]   = r_cmd[p][28:24];
         w_isclk[p] = (w_op[p] == 3'b001) || (w_op[p] == 3'b010);
         w_isch[p]  = w_op[p][2];
         w_ok[p]    = (w_isclk[p] && ({1'b0, w_idx[p]} < LP_NCLK)) ||
                      (w_isch[p] && ({1'b0, w_idx[p]} < LP_NAT) &&
                       (w_op[p][1:0] == 2'b00 || w_op[p][1:0] == 2'b11 ||
                        {2'b00, r_cmd[p][19:16]} < LP_NCLK));
         w_rej[p]   = (w_op[p] != 3'b000) && !w_ok[p];
      end
      w_conf   = w_ok[0] && w_ok[1] && (w_idx[0] == w_idx[1]) &&
                 ((w_isclk[0] && w_isclk[1]) || (w_isch[0] && w_isch[1]));
      w_vld[0] = w_exec && w_ok[0];
      w_vld[1] = w_exec && w_ok[1] && !w_conf;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_stat <= 2'b00;
      else          r_stat <= w_exec ? {w_rej[1] || w_conf, w_rej[0]} : 2'b00;
   end

   always_comb begin
      for (int c = 0; c < N_CLK; c++) begin
         w_ck_hit[c] = 1'b0;
         w_ck_sel[c] = 1'b0;
         for (int p = 0; p < 2; p++)
            if (w_vld[p] && w_isclk[p] && (w_idx[p] == 5'(c))) begin
               w_ck_hit[c] = 1'b1;
               w_ck_sel[c] = 1'(p);
            end
         case (r_rate[c])
            2'd0:    w_tick[c] = 1'b1;
            2'd1:    w_tick[c] = r_presc[0];
            2'd2:    w_tick[c] = &r_presc[1:0];
            default: w_tick[c] = &r_presc;
         endcase
      end
   end

   // A command on a counter suppresses that cycle's increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_presc <= '0; r_cnt <= '0; r_rate <= '0; r_cen <= '0; r_ev <= '0;
      end else begin
         r_presc <= r_presc + 3'd1;
         for (int c = 0; c < N_CLK; c++) begin
            r_ev[c] <= 1'b0;
            if (w_ck_hit[c]) begin
               if (w_op[w_ck_sel[c]] == 3'b001) begin
                  r_cnt[c]  <= r_cmd[w_ck_sel[c]][CW-1:0];
                  r_rate[c] <= r_cmd[w_ck_sel[c]][22:21];
               end else r_cen[c] <= r_cmd[w_ck_sel[c]][23];
            end else if (r_cen[c] && w_tick[c]) begin
               r_cnt[c] <= r_cnt[c] + CW'(1);
               r_ev[c]  <= 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < N_AT; g++) begin : g_ch
      logic w_hit, w_sel;
      always_comb begin
         w_hit = 1'b0;
         w_sel = 1'b0;
         for (int p = 0; p < 2; p++)
            if (w_vld[p] && w_isch[p] && (w_idx[p] == 5'(g))) begin
               w_hit = 1'b1;
               w_sel = 1'(p);
            end
      end
      ats_channel #(.N_CLK(N_CLK), .CW(CW), .PULSE_W(PULSE_W)) u_ch (
         .clk      (clk),
         .reset_n  (reset_n),
         .i_cmd_vld(w_hit),
         .i_cmd_op (w_op[w_sel][1:0]),
         .i_flag   (r_cmd[w_sel][23]),
         .i_mode   (r_cmd[w_sel][22]),
         .i_src    (r_cmd[w_sel][19:16]),
         .i_val    (r_cmd[w_sel][CW-1:0]),
         .i_ev     (r_ev),
         .i_cnt    (r_cnt),
         .o_data   (data[g])
      );
   end
endmodule

// File: tb/tb_ats_timer_array.sv
// Bench for ats_timer_array: directed scenarios plus random commands, scored against
// a cycle-level model of the counter/alarm/timer rules.

module tb_ats_timer_array;
   localparam int N_CLK = 16, N_AT = 24, CW = 16, PULSE_W = 2;

   logic            clk = 1'b0, reset_n = 1'b0, req = 1'b0;
   logic [15:0]     ctrlA = '0, ctrlB = '0;
   logic            ready;
   logic [1:0]      stat;
   logic [N_AT-1:0] data;

   always #5 clk = ~clk;

   ats_timer_array #(.N_CLK(N_CLK), .N_AT(N_AT), .CW(CW), .PULSE_W(PULSE_W)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB),
      .ready(ready), .stat(stat), .data(data));

   typedef struct { logic [1:0] st; logic [N_AT-1:0] d; } exp_t;
   exp_t q[$];
   exp_t mon_e;
   int   n_chk = 0, n_fail = 0;

   // model state
   int  m_cnt[N_CLK], m_rate[N_CLK];
   bit  m_en[N_CLK], m_ev[N_CLK];
   bit  c_en[N_AT], c_lm[N_AT], c_tmr[N_AT], c_arm[N_AT], c_rpt[N_AT], c_lat[N_AT];
   int  c_src[N_AT], c_val[N_AT], c_rem[N_AT], c_end[N_AT];
   int  m_n;
   bit  m_on = 1'b0, pend = 1'b0;
   logic [31:0] pendA = '0, pendB = '0;

   function automatic void m_init();
      for (int c = 0; c < N_CLK; c++) begin
         m_cnt[c] = 0; m_rate[c] = 0; m_en[c] = 0; m_ev[c] = 0;
      end
      for (int i = 0; i < N_AT; i++) begin
         c_en[i] = 0; c_lm[i] = 0; c_tmr[i] = 0; c_arm[i] = 0; c_rpt[i] = 0;
         c_lat[i] = 0; c_src[i] = 0; c_val[i] = 0; c_rem[i] = 0; c_end[i] = 0;
      end
      m_n = 0;
   endfunction

   function automatic void fire(int i);
      if (c_lm[i]) c_lat[i] = 1;
      else         c_end[i] = m_n + PULSE_W;
   endfunction

   function automatic void m_step();
      logic [31:0] cm[2];
      int op[2], idx[2], src[2], v;
      bit ok[2], isclk[2], isch[2], hit;
      exp_t e;
      cm[0] = pendA; cm[1] = pendB;
      e.st = 2'b00;
      for (int p = 0; p < 2; p++) begin
         op[p] = int'(cm[p][31:29]); idx[p] = int'(cm[p][28:24]); src[p] = int'(cm[p][19:16]);
         isclk[p] = (op[p] == 1 || op[p] == 2);
         isch[p]  = (op[p] >= 4);
         ok[p] = 0;
         if (pend && op[p] != 0) begin
            if (isclk[p] && idx[p] < N_CLK) ok[p] = 1;
            else if (isch[p] && idx[p] < N_AT && !((op[p] == 5 || op[p] == 6) && src[p] >= N_CLK)) ok[p] = 1;
            else e.st[p] = 1'b1;
         end
      end
      if (ok[0] && ok[1] && isclk[0] == isclk[1] && idx[0] == idx[1]) begin
         ok[1] = 0; e.st[1] = 1'b1;
      end
      // channels react to counter events of the previous cycle
      for (int i = 0; i < N_AT; i++) begin
         hit = 0;
         for (int p = 0; p < 2; p++)
            if (ok[p] && isch[p] && idx[p] == i) begin
               hit = 1;
               v = int'(cm[p][15:0]) & ((1 << CW) - 1);
               case (op[p])
                  4: c_lat[i] = 0;
                  5: begin c_val[i] = v; c_src[i] = src[p]; c_rpt[i] = cm[p][23]; c_arm[i] = 1; c_tmr[i] = 0; end
                  6: begin c_val[i] = v; c_rem[i] = v; c_src[i] = src[p]; c_rpt[i] = cm[p][23]; c_arm[i] = 1; c_tmr[i] = 1; end
                  default: begin c_en[i] = cm[p][23]; c_lm[i] = cm[p][22]; if (!cm[p][23]) c_lat[i] = 0; end
               endcase
            end
         if (!hit && c_arm[i] && m_ev[c_src[i]]) begin
            if (c_tmr[i]) begin
               if (c_rem[i] <= 1) begin
                  if (c_en[i]) fire(i);
                  if (c_rpt[i]) c_rem[i] = c_val[i]; else c_arm[i] = 0;
               end else c_rem[i] = c_rem[i] - 1;
            end else if (m_cnt[c_src[i]] == c_val[i] && c_en[i]) begin
               fire(i);
               if (!c_rpt[i]) c_arm[i] = 0;
            end
         end
      end
      for (int c = 0; c < N_CLK; c++) begin
         hit = 0;
         for (int p = 0; p < 2; p++)
            if (ok[p] && isclk[p] && idx[p] == c) begin
               hit = 1;
               if (op[p] == 1) begin
                  m_cnt[c] = int'(cm[p][15:0]) & ((1 << CW) - 1);
                  m_rate[c] = int'(cm[p][22:21]);
               end else m_en[c] = cm[p][23];
            end
         m_ev[c] = 0;
         if (!hit && m_en[c] && (m_n % (1 << m_rate[c])) == (1 << m_rate[c]) - 1) begin
            m_cnt[c] = (m_cnt[c] + 1) % (1 << CW);
            m_ev[c] = 1;
         end
      end
      for (int i = 0; i < N_AT; i++) e.d[i] = c_lat[i] || (m_n < c_end[i]);
      q.push_back(e);
      m_n++;
   endfunction

   always @(posedge clk) if (m_on) m_step();

   always @(negedge clk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         n_chk++;
         if (data !== mon_e.d || stat !== mon_e.st) begin
            n_fail++;
            $display("FAIL outputs t=%0t data=%h stat=%b expected data=%h stat=%b",
                     $time, data, stat, mon_e.d, mon_e.st);
         end
      end
   end

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endfunction

   function automatic logic [31:0] mk(int op, int idx, int fl, int rm, int src, int val);
      return {3'(op), 5'(idx), 1'(fl), 2'(rm), 1'b0, 4'(src), 16'(val)};
   endfunction

   function automatic logic [31:0] rnd_cmd();
      int idx;
      idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
      return mk($urandom_range(0, 7), idx, $urandom_range(0, 1), $urandom_range(0, 3),
                $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? int'($urandom) : int'($urandom_range(0, 12)));
   endfunction

   task automatic idle(int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(logic [31:0] a, logic [31:0] b);
      int w = 0;
      while (ready !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
      chk("ready_wait", {31'b0, ready}, 32'd1);
      req = 1'b1; ctrlA = a[31:16]; ctrlB = b[31:16];
      @(posedge clk); #1;
      ctrlA = a[15:0]; ctrlB = b[15:0];
      @(posedge clk); #1;
      req = 1'b0; pendA = a; pendB = b; pend = 1'b1;
      @(posedge clk); #1;
      pend = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; m_on = 1'b0; req = 1'b0;
      #1;
      q.delete();
      chk("rst_ready", {31'b0, ready}, 32'd0);
      chk("rst_stat", {30'b0, stat}, 32'd0);
      chk("rst_data", {8'b0, data}, 32'd0);
      m_init();
      idle(3);
      reset_n = 1'b1; m_on = 1'b1;
      @(posedge clk); #1;
      chk("ready_rise", {31'b0, ready}, 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1);
   end

   initial begin
      m_init();
      #2;
      do_reset();
      // counters: c0 every cycle, c1 every 8 cycles from 5
      send(mk(2, 0, 1, 0, 0, 0), mk(1, 1, 0, 3, 0, 5));
      send(mk(1, 0, 0, 0, 0, 0), mk(2, 1, 1, 0, 0, 0));
      send(mk(7, 4, 1, 0, 0, 0), mk(6, 4, 1, 0, 1, 1));
      // one-shot alarm ch3 at c0 == 10
      send(mk(7, 3, 1, 0, 0, 0), 32'h0);
      send(mk(5, 3, 0, 0, 0, 10), mk(1, 0, 0, 0, 0, 0));
      idle(20);
      // wrap: repeating alarm at 2, counter near the top
      send(mk(1, 0, 0, 0, 0, 16'hFFF8), mk(5, 3, 1, 0, 0, 2));
      idle(24);
      send(mk(1, 0, 0, 0, 0, 16'hFFFC), 32'h0);
      idle(12);
      // latched timer ch23, then ACK
      send(mk(7, 23, 1, 2, 0, 0), mk(6, 23, 0, 0, 0, 4));
      idle(10);
      send(mk(4, 23, 0, 0, 0, 0), 32'h0);
      idle(3);
      // conflicts and rejects
      send(mk(5, 5, 0, 0, 0, 100), mk(5, 5, 0, 0, 0, 200));
      send(mk(5, 30, 0, 0, 0, 1), 32'h0);
      send(mk(3, 0, 0, 0, 0, 0), mk(1, 20, 0, 0, 0, 0));
      send(mk(7, 6, 1, 0, 0, 0), mk(6, 6, 0, 0, 1, 0));
      idle(20);
      // latch ch23 again, then reset between beats
      send(mk(6, 23, 0, 0, 0, 2), 32'h0);
      idle(6);
      req = 1'b1; ctrlA = 16'hA305; ctrlB = 16'hC800;
      @(posedge clk); #1;
      req = 1'b0;
      do_reset();
      send(mk(7, 23, 1, 2, 0, 0), mk(2, 0, 1, 0, 0, 0));
      send(mk(6, 23, 0, 0, 0, 3), 32'h0);
      idle(8);
      for (int k = 0; k < 300; k++) begin
         send(rnd_cmd(), rnd_cmd());
         idle($urandom_range(0, 5));
      end
      idle(10);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ats_timer_array.md
# ats_timer_array

Parametrised alarm/timer engine: next generation of the ATS21 alarm/timer resource model. Holds N_CLK free-running base counters and N_AT alarm/timer channels, configured through two 16-bit command ports (A, B) that each deliver a 32-bit command in two beats. Each channel drives one bit of `data`, either as a fixed-width pulse or as a level latched until acknowledged. Sits between the host command interface and event consumers.

## Interface
- N_CLK, 16: base counters (1..16)
- N_AT, 24: alarm/timer channels (1..32)
- CW, 16: counter/target width (1..16); command value field truncated to CW LSBs
- PULSE_W, 2: `data` high time in pulse mode, cycles (1..15)
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  1  command beat valid
- ctrlA  in  16  port A beat
- ctrlB  in  16  port B beat
- ready  out  1  beat accepted when req && ready
- stat  out  2  bit0 port A / bit1 port B: 1-cycle pulse, command rejected
- data  out  N_AT  channel fire outputs

## Operation
- Command word: [31:29] opcode, [28:24] index, [23] flag, [22:21] rate/mode, [19:16] source counter, [15:0] value.
- Opcodes: 000 NOP; 001 SET_CLK (preload counter idx = value, rate = [22:21]); 010 CLK_EN (counter idx enable = flag); 100 ACK (clear latched `data[idx]`); 101 SET_ALARM (target = value, src = [19:16], repeat = flag, arm); 110 SET_TIMER (reload = remaining = value, src, repeat = flag, arm); 111 AT_EN (channel enable = flag, latch mode = [22]); 011 reserved.
- Reject (stat pulse, no state change): opcode 011; clock op with idx >= N_CLK; channel op with idx >= N_AT or src >= N_CLK.
- Both ports executed in same cycle; if both write the same counter or channel, A applies, B rejected.
- Prescaler: 3-bit free-running. Rate r ticks every 2^r cycles (r=3 → every 8), when low r bits of prescaler are all 1.
- Counter increments on its tick if enabled; wraps 2^CW-1 → 0. Increment = "source event".
- Alarm: on source event where new value == target, channel enabled and armed → fire. One-shot disarms; repeat stays armed (fires every wrap).
- Timer: each source event decrements remaining; transition to 0 fires (value 0 loaded = fire on first event). Repeat reloads; one-shot disarms. Counting needs armed only; firing needs enable.
- Fire: pulse mode drives `data[i]` high PULSE_W cycles (refire restarts width); latch mode holds high until ACK, AT_EN disable, or reset.
- Command writing a counter in the same cycle as its tick: command wins, no increment.

## Timing
- Reset (async assert, sync release): ready=0, stat=0, data=0, counters=0, all disabled/disarmed, rate=0, prescaler=0, FSM=HI.
- FSM: HI (ready=1) —req→ LO (ready=1) —req→ EXEC (ready=0) → HI. Upper halves captured in HI, lower in LO; req low holds state. ready rises first cycle after reset_n release.
- EXEC: command applied at the end of EXEC; stat asserted during the cycle after EXEC; next upper beat accepted the cycle after EXEC.
- Counter update at edge k; fire compare uses new value; `data` high from edge k+1.
- reset_n low mid-command discards partial beats; mid-pulse clears `data` immediately.

## Test plan
- Reset, then CLK_EN c0 on, SET_CLK c0 value 0 rate 0 → counter increments every cycle; 0xFFFF wraps to 0.
- SET_CLK c1 rate 3, value 5, enabled → c1 increments exactly once per 8 cycles.
- AT_EN ch3 pulse, SET_ALARM ch3 src c0 target 10 one-shot → data[3] high 2 cycles after c0 reaches 10, never again after wrap; repeat=1 → fires each wrap.
- AT_EN ch23 latch, SET_TIMER ch23 src c0 value 4 → data[23] rises 1 cycle after 4th c0 increment, holds until ACK ch23, then low next cycle.
- Port A and B both SET_ALARM ch5 same cycle → A's target used, stat=2'b10 one cycle; A idx 30 with N_AT=24 → stat[0] pulse.
- reset_n low between upper and lower beats → FSM HI, no state change, data=0.
